// File: rtl/image_receiver_if.sv
// Pixel receive link: serial line in, frame-buffer write port out.
interface image_receiver_if;
    logic        uart_in;
    logic [11:0] pixel;
    logic [16:0] address;
    logic        wr_en;
    logic        image_ready;
    logic        frame_err;

    modport master (
        output uart_in,
        input  pixel, address, wr_en, image_ready, frame_err
    );

    modport slave (
        input  uart_in,
        output pixel, address, wr_en, image_ready, frame_err
    );
endinterface

// File: rtl/image_receiver.sv
// UART 8N1 receiver that rebuilds 12-bit pixels from byte pairs and writes them to a frame buffer.
// Optional macro RX_RESYNC_EN: discard a stranded high byte after RESYNC_CLKS idle clocks.
module image_receiver #(
    parameter int unsigned NUM_PIXELS  = 100,
    parameter int unsigned CLK_FREQ    = 50_000_000,
    parameter int unsigned BAUD_RATE   = 9600,
    parameter int unsigned RESYNC_CLKS = 2500
) (
    input  logic            clk,
    input  logic            rst,
    image_receiver_if.slave bus
);
    localparam int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
    localparam int unsigned CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned ADDR_W       = 17;
    localparam logic [CNT_W-1:0]  HALF_TICK = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_TICK = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIXELS);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} rx_state_t;

    rx_state_t  state, state_next;
    logic       sync_q1, sync_q2, line_prev;
    logic       fall_c;
    logic [CNT_W-1:0] cnt;
    logic [2:0] bit_idx;
    logic [7:0] rx_byte;
    logic       cnt_clr_c, shift_en_c, byte_valid_c, frame_err_c;
    logic       resync_c;
    logic       phase_lo;
    logic [3:0] hi_nib;

    // Two-flop synchroniser plus one delayed copy for falling-edge detection
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q1   <= 1'b1;
            sync_q2   <= 1'b1;
            line_prev <= 1'b1;
        end else begin
            sync_q1   <= bus.uart_in;
            sync_q2   <= sync_q1;
            line_prev <= sync_q2;
        end
    end

    assign fall_c = line_prev & ~sync_q2;

    always_ff @(posedge clk) begin
        if (rst) state <= S_IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (fall_c) state_next = S_START;
            S_START: if (cnt == HALF_TICK) state_next = sync_q2 ? S_IDLE : S_DATA;
            S_DATA:  if (cnt == FULL_TICK && bit_idx == 3'd7) state_next = S_STOP;
            S_STOP:  if (cnt == FULL_TICK) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cnt_clr_c    = 1'b0;
        shift_en_c   = 1'b0;
        byte_valid_c = 1'b0;
        frame_err_c  = 1'b0;
        case (state)
            S_IDLE:  cnt_clr_c = 1'b1;
            S_START: cnt_clr_c = (cnt == HALF_TICK);
            S_DATA: begin
                cnt_clr_c  = (cnt == FULL_TICK);
                shift_en_c = (cnt == FULL_TICK);
            end
            S_STOP: begin
                cnt_clr_c    = (cnt == FULL_TICK);
                byte_valid_c = (cnt == FULL_TICK) &  sync_q2;
                frame_err_c  = (cnt == FULL_TICK) & ~sync_q2;
            end
            default: cnt_clr_c = 1'b1;
        endcase
    end

    // Bit timing counter and LSB-first data capture
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            bit_idx <= 3'd0;
            rx_byte <= 8'h00;
        end else begin
            cnt <= cnt_clr_c ? '0 : cnt + 1'b1;
            if (state == S_START) bit_idx <= 3'd0;
            if (shift_en_c) begin
                rx_byte[bit_idx] <= sync_q2;
                bit_idx          <= bit_idx + 1'b1;
            end
        end
    end

`ifdef RX_RESYNC_EN
    localparam int unsigned IDLE_W = $clog2(RESYNC_CLKS + 1);
    localparam logic [IDLE_W-1:0] IDLE_LIMIT = IDLE_W'(RESYNC_CLKS);

    logic [IDLE_W-1:0] idle_cnt;

    // Counts quiet line time while a high nibble waits for its low byte
    always_ff @(posedge clk) begin
        if (rst || fall_c || !phase_lo) idle_cnt <= '0;
        else if (state == S_IDLE && idle_cnt != IDLE_LIMIT) idle_cnt <= idle_cnt + 1'b1;
    end

    assign resync_c = phase_lo && (state == S_IDLE) && (idle_cnt == IDLE_LIMIT);
`else
    assign resync_c = 1'b0;
`endif

    // Pixel assembly and frame-buffer write sequencing
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_lo        <= 1'b0;
            hi_nib          <= 4'h0;
            bus.pixel       <= 12'h000;
            bus.address     <= '0;
            bus.wr_en       <= 1'b0;
            bus.image_ready <= 1'b0;
            bus.frame_err   <= 1'b0;
        end else begin
            bus.wr_en     <= 1'b0;
            bus.frame_err <= frame_err_c;
            if (frame_err_c || resync_c) begin
                phase_lo <= 1'b0;
                hi_nib   <= 4'h0;
            end else if (byte_valid_c) begin
                if (!phase_lo) begin
                    // A non-zero upper nibble means we caught a low byte out of step
                    if (rx_byte[7:4] == 4'h0) begin
                        hi_nib   <= rx_byte[3:0];
                        phase_lo <= 1'b1;
                    end
                end else begin
                    bus.pixel <= {hi_nib, rx_byte};
                    phase_lo  <= 1'b0;
                    bus.wr_en <= ~bus.image_ready;
                end
            end
            if (bus.wr_en) begin
                bus.address <= bus.address + 1'b1;
                if (bus.address + 1'b1 == LAST_ADDR) bus.image_ready <= 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_image_receiver.sv
// Scoreboard bench for image_receiver: directed byte streams, expected writes queued and checked by a monitor.
module tb_image_receiver;
    localparam int unsigned NUM_PIXELS = 4;
    localparam int unsigned CPB        = 10;

    typedef struct packed {
        logic [11:0] pix;
        logic [16:0] addr;
    } exp_t;

    logic clk;
    logic rst;
    image_receiver_if bus();

    image_receiver #(
        .NUM_PIXELS (NUM_PIXELS),
        .CLK_FREQ   (50_000_000),
        .BAUD_RATE  (5_000_000),
        .RESYNC_CLKS(2500)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_pass   = 0;
    int   fe_cycles = 0;
    exp_t exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    endtask

    // Monitor: every write strobe is matched against the head of the expected queue
    bit          addr_chk_pend = 1'b0;
    logic [16:0] addr_after;
    always @(negedge clk) begin
        exp_t e;
        if (bus.frame_err === 1'b1) fe_cycles++;
        if (addr_chk_pend) begin
            addr_chk_pend = 1'b0;
            check("addr_inc", 32'(bus.address), 32'(addr_after) + 1);
            if (32'(addr_after) + 1 == NUM_PIXELS) check("image_ready_set", 32'(bus.image_ready), 32'd1);
        end
        if (bus.wr_en === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_write: got pixel=0x%0h addr=%0d expected no write at %0t",
                         bus.pixel, bus.address, $time);
            end else begin
                e = exp_q.pop_front();
                check("wr_pixel", 32'(bus.pixel), 32'(e.pix));
                check("wr_addr", 32'(bus.address), 32'(e.addr));
                addr_chk_pend = 1'b1;
                addr_after    = e.addr;
            end
        end
    end

    task automatic wait_clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        bus.uart_in = 1'b1;
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(2);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_bit);
        bus.uart_in = 1'b0;
        wait_clks(CPB);
        for (int i = 0; i < 8; i++) begin
            bus.uart_in = b[i];
            wait_clks(CPB);
        end
        bus.uart_in = stop_bit;
        wait_clks(CPB);
        bus.uart_in = 1'b1;
    endtask

    task automatic send_pixel(input logic [11:0] p);
        send_byte({4'h0, p[11:8]}, 1'b1);
        send_byte(p[7:0], 1'b1);
    endtask

    task automatic push(input logic [11:0] pix, input logic [16:0] addr);
        exp_t e;
        e.pix  = pix;
        e.addr = addr;
        exp_q.push_back(e);
    endtask

    task automatic drain(input string name);
        int waited;
        waited = 0;
        while (exp_q.size() > 0 && waited < 3000) begin
            wait_clks(1);
            waited++;
        end
        wait_clks(30);
        check(name, 32'(exp_q.size()), 32'd0);
        if (exp_q.size() > 0) exp_q.delete();
    endtask

    initial begin
        int fe0;
        logic [11:0] frame_pix [4];
        frame_pix[0] = 12'h001;
        frame_pix[1] = 12'h7FF;
        frame_pix[2] = 12'h800;
        frame_pix[3] = 12'hFFF;

        // Reset state
        do_reset();
        check("rst_pixel", 32'(bus.pixel), 32'd0);
        check("rst_address", 32'(bus.address), 32'd0);
        check("rst_wr_en", 32'(bus.wr_en), 32'd0);
        check("rst_image_ready", 32'(bus.image_ready), 32'd0);
        check("rst_frame_err", 32'(bus.frame_err), 32'd0);

        // Basic pixel
        fe0 = fe_cycles;
        push(12'hABC, 17'd0);
        send_byte(8'h0A, 1'b1);
        send_byte(8'hBC, 1'b1);
        drain("basic_drain");
        check("basic_no_frame_err", 32'(fe_cycles - fe0), 32'd0);

        // Full frame then an overflow pixel
        do_reset();
        for (int i = 0; i < 4; i++) begin
            push(frame_pix[i], 17'(i));
            send_pixel(frame_pix[i]);
        end
        drain("frame_drain");
        check("frame_ready", 32'(bus.image_ready), 32'd1);
        check("frame_addr", 32'(bus.address), 32'd4);
        send_pixel(12'h123);
        wait_clks(30);
        check("overflow_addr", 32'(bus.address), 32'd4);
        check("overflow_ready", 32'(bus.image_ready), 32'd1);

        // Bad stop bit
        do_reset();
        fe0 = fe_cycles;
        send_byte(8'h0A, 1'b0);
        wait_clks(10);
        check("badstop_frame_err_pulse", 32'(fe_cycles - fe0), 32'd1);
        push(12'h123, 17'd0);
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        drain("badstop_drain");

        // Start glitch
        do_reset();
        fe0 = fe_cycles;
        bus.uart_in = 1'b0;
        wait_clks(3);
        bus.uart_in = 1'b1;
        wait_clks(40);
        check("glitch_no_frame_err", 32'(fe_cycles - fe0), 32'd0);
        check("glitch_addr", 32'(bus.address), 32'd0);
        push(12'h567, 17'd0);
        send_byte(8'h05, 1'b1);
        send_byte(8'h67, 1'b1);
        drain("glitch_drain");

        // Misaligned byte, then reset in the middle of a pixel
        do_reset();
        send_byte(8'hBC, 1'b1);
        send_byte(8'h0A, 1'b1);
        bus.uart_in = 1'b0;
        wait_clks(CPB);
        bus.uart_in = 1'b1;
        wait_clks(3 * CPB);
        rst = 1'b1;
        wait_clks(3);
        rst = 1'b0;
        wait_clks(20);
        check("midrst_addr", 32'(bus.address), 32'd0);
        push(12'hFFF, 17'd0);
        send_byte(8'h0F, 1'b1);
        send_byte(8'hFF, 1'b1);
        drain("midrst_drain");

        // Stranded high byte followed by a long idle gap
        do_reset();
        send_byte(8'h0A, 1'b1);
        wait_clks(2600);
`ifdef RX_RESYNC_EN
        push(12'h123, 17'd0);
`else
        push(12'hA01, 17'd0);
`endif
        send_byte(8'h01, 1'b1);
        send_byte(8'h23, 1'b1);
        drain("resync_drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/image_receiver.md
Name: image_receiver

Overview:
- Receiving end of the camera-over-UART link. Deserialises the byte stream produced by the pixel transmitter and rebuilds 12-bit pixels.
- Writes each pixel into a frame buffer through an address / write-strobe interface.
- Flags image_ready once NUM_PIXELS pixels have been stored.
- Sits between the UART RX pin and the frame-buffer write port on the receiving FPGA.

Parameters:
- NUM_PIXELS, 100: pixels per frame; address range 0..NUM_PIXELS-1.
- CLK_FREQ, 50_000_000: clk frequency in Hz.
- BAUD_RATE, 9600: UART bit rate. CLKS_PER_BIT = CLK_FREQ/BAUD_RATE (integer division).
- RESYNC_CLKS, 2500: idle clocks, with half a pixel pending, after which the pending high byte is discarded. Used only with RX_RESYNC_EN.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- uart_in, input, 1: asynchronous serial line; idle high; 8N1, LSB first.
- pixel, output, 12: assembled pixel, valid while wr_en=1.
- address, output, 17: frame-buffer write address.
- wr_en, output, 1: one-cycle write strobe.
- image_ready, output, 1: frame complete, held high.
- frame_err, output, 1: one-cycle pulse on a bad stop bit.

Behaviour:
- Reset values:
  - pixel=0, address=0, wr_en=0, image_ready=0, frame_err=0.
  - Synchroniser flops = 1.
  - RX FSM = IDLE; byte phase = HI.
- Input conditioning: uart_in passes through a 2-flop synchroniser. Start detection uses a falling edge of the synchronised line (prev=1, cur=0).
- RX FSM, single counter cnt:
  - IDLE: on falling edge, cnt=0, go to START.
  - START: at cnt=CLKS_PER_BIT/2-1, sample the line.
    - 0: cnt=0, bit index=0, go to DATA.
    - 1: glitch; go to IDLE with no output.
  - DATA: every CLKS_PER_BIT clocks, shift the sample into bit[index], LSB first. After bit 7, go to STOP.
  - STOP: after CLKS_PER_BIT clocks, sample the line.
    - 1: byte_valid internal pulse.
    - 0: frame_err=1 for one cycle; byte dropped; byte phase forced to HI.
    - Either way, return to IDLE. A held-low line (break) starts no new byte until it returns high and falls again.
- Wire format: each pixel is two bytes.
  - High byte first: {4'b0000, pixel[11:8]}.
  - Then low byte: pixel[7:0].
- Byte assembler:
  - Phase HI:
    - If byte[7:4]==0: store byte[3:0] as hi_nib; go to LO.
    - Otherwise: drop the byte (misaligned low byte) and stay in HI.
  - Phase LO: on the next byte, set pixel={hi_nib, byte}; go to HI.
    - If image_ready=0: wr_en=1 for exactly one cycle.
- Timing:
  - wr_en asserts on the cycle after the STOP-sample cycle.
  - address is stable and equals the write index during wr_en.
  - address increments on the cycle after wr_en.
- End of frame:
  - When the increment makes address==NUM_PIXELS, image_ready=1 on that same cycle and address holds at NUM_PIXELS.
  - While image_ready=1, further complete pixels produce no wr_en and no address change. Only rst clears this.
- Simultaneous events: rst overrides all. A new falling edge seen on the same cycle as wr_en is accepted normally, because the RX FSM and the assembler are independent.
- Reset mid-byte or mid-pixel: the partial byte and hi_nib are discarded; reception restarts at the next falling edge.
- Width rules:
  - address is 17 bits; NUM_PIXELS must be ≤ 2^17-1.
  - cnt is sized for CLKS_PER_BIT-1.

Optional Feature:
- Macro: RX_RESYNC_EN.
- Defined:
  - An idle counter runs while phase=LO and the RX FSM is in IDLE. It clears on every falling edge.
  - On reaching RESYNC_CLKS, phase is set to HI and hi_nib is discarded, with no wr_en and no frame_err.
  - This restores pixel alignment after a lost byte, because the transmitter leaves its inter-pixel delay between pixels.
- Not defined: no idle counter. Alignment recovers only through the upper-nibble check or rst.

Test Plan:
- Bench parameters for all scenarios: BAUD_RATE=5_000_000, so CLKS_PER_BIT=10; NUM_PIXELS=4.
- Basic pixel:
  - Send bytes 0x0A, 0xBC.
  - Expect exactly one wr_en with pixel=0xABC and address=0; address=1 the next cycle; frame_err never asserted.
- Full frame: send pixels 0x001, 0x7FF, 0x800, 0xFFF.
  - Expect wr_en at addresses 0..3 with those values.
  - Expect image_ready=1 in the cycle after the 4th wr_en, with address=4.
  - Then send a 5th pixel 0x123: no wr_en, address stays 4.
- Bad stop bit:
  - Send 0x0A with the stop bit driven 0: expect a one-cycle frame_err pulse and no wr_en.
  - Then send 0x01, 0x23: expect pixel=0x123 at address 0.
- Start glitch:
  - Pulse uart_in low for 3 clocks: expect FSM back in IDLE, no byte received, no outputs.
  - Then send 0x05, 0x67: expect pixel=0x567.
- Misaligned and mid-frame reset:
  - Send 0xBC alone: expect it dropped, phase stays HI.
  - Send 0x0A, then assert rst during the next byte's DATA bits.
  - After reset, send 0x0F, 0xFF: expect pixel=0xFFF at address 0.
- RX_RESYNC_EN defined: send 0x0A, idle 2600 clocks with RESYNC_CLKS=2500, then send 0x01, 0x23.
  - Expect pixel=0x123, not 0xA01.
  - Without the macro, the same stimulus yields pixel=0xA01.
